// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared state encoding and requester indices for shift_seq_ctrl
package shift_ctrl_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;
  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin pick with a registered priority pointer
//   clk, clr_n : clock, synchronous active-low reset (pointer favours requester 0)
//   req        : request levels
//   adv        : advance pointer this cycle (end of a transaction)
//   won1       : 1 when requester 1 owns the finishing transaction
//   win        : combinational one-hot (or zero) winner
module rr_arb2
  import shift_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       won1,
  output logic [1:0] win
);
  logic ptr_q, ptr_d;
  // pointer=1 favours requester 1; after a transaction it favours the loser
  always_comb ptr_d = adv ? ~won1 : ptr_q;
  always_ff @(posedge clk) ptr_q <= clr_n ? ptr_d : 1'b0;
  assign win = (req[REQ0] && req[REQ1]) ? (ptr_q ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: arbitrates two requesters and serially loads the winner's word into a shared shift register
//   clk, clr_n     : clock, synchronous active-low reset
//   req            : request levels, one per requester
//   data0, data1   : parallel words, sampled only in the grant cycle
//   gnt, done      : one-hot grant for the transaction, one-cycle completion pulse
//   busy           : high outside IDLE
//   sr_clr, sr_en, sr_in : clear strobe, shift enable and serial bit for the register
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             sr_clr,
  output logic             sr_en,
  output logic             sr_in
);
  localparam int CNT_W = $clog2(WIDTH);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [1:0]       gnt_q, done_q, win;
  logic             busy_q, sr_clr_q, sr_en_q, sr_in_q, last;
  assign hold_d = hold_q >> 1;
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  rr_arb2 u_arb (
    .clk  (clk),
    .clr_n(clr_n),
    .req  (req),
    .adv  (state_q == DONE),
    .won1 (gnt_q[REQ1]),
    .win  (win)
  );
  // outputs are loaded on the edge that enters each state, so they line up with it
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      busy_q   <= 1'b0;
      sr_clr_q <= 1'b0;
      sr_en_q  <= 1'b0;
      sr_in_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          state_q  <= CLEAR;
          gnt_q    <= win;
          hold_q   <= win[REQ1] ? data1 : data0;
          busy_q   <= 1'b1;
          sr_clr_q <= 1'b1;
        end
        CLEAR: begin
          state_q  <= SHIFT;
          sr_clr_q <= 1'b0;
          sr_en_q  <= 1'b1;
          sr_in_q  <= hold_q[0];
          hold_q   <= hold_d;
          cnt_q    <= '0;
        end
        SHIFT: if (last) begin
          state_q <= DONE;
          sr_en_q <= 1'b0;
          sr_in_q <= 1'b0;
          done_q  <= gnt_q;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          sr_in_q <= hold_q[0];
          hold_q  <= hold_d;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign sr_clr = sr_clr_q;
  assign sr_en  = sr_en_q;
  assign sr_in  = sr_in_q;
endmodule
